pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the MIPS32 core. It merges per-stage stall requests into a per-stage hold vector and sequences pipeline flushes, supplying a redirect PC. It also tracks stall and flush statistics and runs a stall watchdog. It sits beside the pc_reg/if_id/id_ex/ex_mem/mem_wb chain and drives their hold and flush inputs.

Parameters:
STAGES, 6, number of pipeline stages; index 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
ADDR_W, 32, width of the redirect PC.
CNT_W, 16, width of the statistics counters.
FLUSH_CYCLES, 1, number of cycles flush_o stays high per flush; legal range 1..15.
WDOG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog; must be at least 2 and below 2^CNT_W.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
stallreq_i  in  STAGES  per-stage stall request; bit i = stage i needs to hold.
flush_req_i  in  1  flush request; one-cycle pulse or level.
flush_pc_i  in  ADDR_W  redirect target; sampled when flush_req_i is high.
wdog_clr_i  in  1  clears the sticky watchdog flag.
stall_o  out  STAGES  hold vector; stall_o[i]=1 means stage i keeps its contents.
flush_o  out  1  flush all pipeline registers.
new_pc_o  out  ADDR_W  redirect PC; valid while flush_o=1.
busy_o  out  1  FSM is in the FLUSH state.
wdog_o  out  1  sticky watchdog-tripped flag.
stall_cnt_o  out  CNT_W  cycles in which stall_o[0]=1, saturating.
flush_cnt_o  out  CNT_W  number of flush sequences entered, saturating.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - all outputs to 0;
  - the FSM to RUN;
  - all internal counters to 0.
  - While rst=1, stall_o and flush_o are forced to 0 combinationally.
  - Reset has priority over everything, including mid-FLUSH.
- Stall vector (combinational, same cycle):
  - In RUN, let k = highest index i with stallreq_i[i]=1.
  - stall_o[j]=1 for all j<=k; stall_o=0 when stallreq_i=0.
  - A downstream stage with stall_o[j]=0 while stall_o[j-1]=1 receives a bubble. Inserting that bubble is the pipeline register's job, not this block's.
  - In FLUSH, stall_o=0 regardless of stallreq_i.
- FSM states:
  - RUN to FLUSH: flush_req_i=1 at a clock edge. new_pc_o <= flush_pc_i; cycle counter <= 0; flush_cnt_o increments (saturating).
  - FLUSH: flush_o=1 and busy_o=1.
    - Counter increments each cycle.
    - Return to RUN after FLUSH_CYCLES cycles in FLUSH.
    - flush_req_i=1 while in FLUSH re-latches new_pc_o, restarts the counter and increments flush_cnt_o.
  - Latency: flush_o rises exactly one cycle after flush_req_i is sampled and stays high for exactly FLUSH_CYCLES cycles, absent a re-request.
- Priority: flush beats stall. stallreq_i in the same cycle as flush_req_i still produces a stall_o that cycle, because the FSM is still in RUN. The following cycles show stall_o=0.
- new_pc_o holds its last latched value outside FLUSH.
- stall_cnt_o increments on every cycle with stall_o[0]=1 and holds at all-ones.
- Watchdog:
  - An internal run counter increments each cycle stall_o!=0 and resets to 0 on any cycle with stall_o=0.
  - When the run counter reaches WDOG_LIMIT-1 while stall_o!=0, wdog_o <= 1 (sticky).
  - The run counter saturates at WDOG_LIMIT.
  - wdog_clr_i=1 clears wdog_o next cycle and zeroes the run counter.
  - If a trip and a clear occur in the same cycle, the clear wins.
- The watchdog does not itself force a flush; the exception logic reacts to wdog_o.

Test Plan:
- Reset with stallreq_i=6'b001000 held -> during reset stall_o=0, all counters 0; first cycle after reset stall_o=6'b001111.
- stallreq_i=6'b000100 for 3 cycles, then 0 -> stall_o=6'b000111 for those 3 cycles, then 0; stall_cnt_o=3.
- FLUSH_CYCLES=2; flush_req_i pulse with flush_pc_i=32'h0000_0100 and stallreq_i=6'b010000 in the same cycle -> that cycle stall_o=6'b011111; flush_o=1 and new_pc_o=32'h100 for the next 2 cycles with stall_o=0; flush_cnt_o=1.
- FLUSH_CYCLES=3; second flush_req_i with pc 32'h200 during the 2nd FLUSH cycle -> new_pc_o=32'h200, flush_o stays high 3 more cycles (5 total); flush_cnt_o=2.
- WDOG_LIMIT=4; stallreq_i[2]=1 held 10 cycles -> wdog_o rises after the 4th stalled cycle and stays high; wdog_clr_i pulse while the stall persists -> wdog_o=0 next cycle and re-trips 4 cycles later.
- CNT_W=4; 20 stalled cycles -> stall_cnt_o saturates at 4'hF; rst mid-FLUSH -> flush_o=0 immediately and FSM in RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush sequencer with stall statistics and watchdog
module pipe_ctrl #(
  parameter int STAGES       = 6,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              flush_req_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              wdog_clr_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              busy_o,
  output logic              wdog_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0]       FC_LAST  = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WDOG_LIMIT);
  localparam logic [CNT_W-1:0] WD_TRIP  = CNT_W'(WDOG_LIMIT - 1);

  state_t              state_q, state_d;
  logic [3:0]          fcyc_q, fcyc_d;
  logic [ADDR_W-1:0]   pc_d;
  logic                flush_enter;
  logic [STAGES-1:0]   stall_vec;
  logic [CNT_W-1:0]    run_q;

  // Hold every stage at or upstream of the highest-index requester
  always_comb begin
    logic any;
    any       = 1'b0;
    stall_vec = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      any          = any | stallreq_i[i];
      stall_vec[i] = any;
    end
  end

  // Flush dominates stalls; reset masks both hold and flush immediately
  always_comb begin
    stall_o = (rst || state_q == FLUSH) ? '0 : stall_vec;
    flush_o = (state_q == FLUSH) && !rst;
    busy_o  = (state_q == FLUSH);
  end

  // Next-state logic: a request in either state (re)starts the flush window
  always_comb begin
    state_d     = state_q;
    fcyc_d      = fcyc_q;
    pc_d        = new_pc_o;
    flush_enter = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_req_i) begin
          state_d     = FLUSH;
          fcyc_d      = 4'd0;
          pc_d        = flush_pc_i;
          flush_enter = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_req_i) begin
          fcyc_d      = 4'd0;
          pc_d        = flush_pc_i;
          flush_enter = 1'b1;
        end else if (fcyc_q == FC_LAST) begin
          state_d = RUN;
          fcyc_d  = 4'd0;
        end else begin
          fcyc_d = fcyc_q + 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        fcyc_d  = 4'd0;
      end
    endcase
  end

  // FSM, redirect PC and flush-window counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      fcyc_q   <= 4'd0;
      new_pc_o <= '0;
    end else begin
      state_q  <= state_d;
      fcyc_q   <= fcyc_d;
      new_pc_o <= pc_d;
    end
  end

  // Saturating statistics: stalled PC cycles and flush sequences started
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o[0] && stall_cnt_o != CNT_MAX) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_enter && flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

  // Watchdog: consecutive-stall run length, sticky trip flag, clear wins over trip
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      wdog_o <= 1'b0;
    end else if (wdog_clr_i) begin
      run_q  <= '0;
      wdog_o <= 1'b0;
    end else if (stall_o != '0) begin
      if (run_q == WD_TRIP) wdog_o <= 1'b1;
      if (run_q != WD_LIMIT) run_q <= run_q + 1'b1;
    end else begin
      run_q <= '0;
    end
  end

endmodule
